// File: rtl/apu_frame_sequencer_pkg.sv
// Shared step/mode encodings and cfg bit positions for the APU frame sequencer.
package apu_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    STEP_0 = 3'd0,
    STEP_1 = 3'd1,
    STEP_2 = 3'd2,
    STEP_3 = 3'd3,
    STEP_4 = 3'd4
  } step_e;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  localparam int CFG_MODE_BIT    = 7;
  localparam int CFG_INHIBIT_BIT = 6;

  // Step 3 wraps to 0 in 4-step mode, so STEP_4 is only reachable in 5-step mode.
  function automatic step_e next_step(input step_e s, input mode_e m);
    step_e r;
    case (s)
      STEP_0:  r = STEP_1;
      STEP_1:  r = STEP_2;
      STEP_2:  r = STEP_3;
      STEP_3:  r = (m == MODE_5STEP) ? STEP_4 : STEP_0;
      default: r = STEP_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apu_frame_sequencer_frame_divider.sv
// Free-running modulo-DIV counter; boundary is high in the cycle where count == DIV-1.
module frame_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic boundary
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign boundary = (count == LAST);

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 4/5-step pattern driving quarter/half ticks and a frame IRQ.
// Define APU_FRAME_IRQ_EN to build the IRQ flag, inhibit latch and irq_ack logic.
module apu_frame_sequencer
  import apu_frame_sequencer_pkg::*;
#(
  parameter int CLKRATE   = 2_000_000,
  parameter int FRAMERATE = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  input  logic       irq_ack,
  output logic       quarter_tick,
  output logic       half_tick,
  output logic       irq,
  output logic [2:0] step
);

  localparam int DIV = CLKRATE / FRAMERATE;

  // cfg_we and irq_ack are single-cycle strobes with no back-pressure: a write is
  // taken in the cycle it is high and always wins over a coincident boundary.

  step_e step_q, step_n;
  mode_e mode_q;
  logic  boundary;
  logic  quarter_d, half_d;
  logic  frame_end;

  frame_divider #(.DIV(DIV)) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cfg_we),
    .boundary (boundary)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= STEP_0;
    end else begin
      step_q <= step_n;
    end
  end

  always_comb begin
    step_n = step_q;
    if (cfg_we) begin
      step_n = STEP_0;
    end else if (boundary) begin
      step_n = next_step(step_q, mode_q);
    end
  end

  // Tick decode for the step that is ending; a 5-step write fires both ticks at once.
  always_comb begin
    quarter_d = 1'b0;
    half_d    = 1'b0;
    frame_end = 1'b0;
    if (cfg_we) begin
      quarter_d = cfg_data[CFG_MODE_BIT];
      half_d    = cfg_data[CFG_MODE_BIT];
    end else if (boundary) begin
      if (mode_q == MODE_4STEP) begin
        quarter_d = 1'b1;
        half_d    = (step_q == STEP_1) || (step_q == STEP_3);
        frame_end = (step_q == STEP_3);
      end else begin
        quarter_d = (step_q != STEP_3);
        half_d    = (step_q == STEP_1) || (step_q == STEP_4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_4STEP;
      quarter_tick <= 1'b0;
      half_tick    <= 1'b0;
    end else begin
      quarter_tick <= quarter_d;
      half_tick    <= half_d;
      if (cfg_we) begin
        mode_q <= mode_e'(cfg_data[CFG_MODE_BIT]);
      end
    end
  end

  assign step = step_q;

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_q;
  logic irq_q;
  logic unused_cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (cfg_we) begin
        inhibit_q <= cfg_data[CFG_INHIBIT_BIT];
      end
      // Priority: inhibit write clears, then a frame-end set, then ack clears.
      if (cfg_we && cfg_data[CFG_INHIBIT_BIT]) begin
        irq_q <= 1'b0;
      end else if (frame_end && !inhibit_q) begin
        irq_q <= 1'b1;
      end else if (irq_ack) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign irq        = irq_q;
  assign unused_cfg = ^cfg_data[5:0];
`else
  logic unused_irq;

  assign irq        = 1'b0;
  assign unused_irq = ^{cfg_data[6:0], irq_ack, frame_end};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer (DIV = 10); honours APU_FRAME_IRQ_EN.
module tb_apu_frame_sequencer;

  localparam int DIV = 10;
  localparam int W   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       irq_ack = 1'b0;
  logic       quarter_tick, half_tick, irq;
  logic [2:0] step;

  int n_cmp = 0;
  int n_err = 0;

  apu_frame_sequencer #(.CLKRATE(2400), .FRAMERATE(240)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_data     (cfg_data),
    .irq_ack      (irq_ack),
    .quarter_tick (quarter_tick),
    .half_tick    (half_tick),
    .irq          (irq),
    .step         (step)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame position is tracked as cycles since the last restart; ticks and steps
  // follow from integer division of that position by DIV.
  int m_pos;
  bit m_mode, m_inh, m_irq, m_imm;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_out();
    int  n, k;
    bit  e, q, h;
    n = m_mode ? 5 : 4;
    e = (m_pos > 0) && (m_pos % DIV == 0);
    k = e ? ((m_pos / DIV - 1) % n) : 0;
    q = m_imm || (e && (m_mode ? (k != 3) : 1'b1));
    h = m_imm || (e && (m_mode ? (k == 1 || k == 4) : (k == 1 || k == 3)));
    return {m_irq, h, q, 3'((m_pos / DIV) % n)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_imm = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      if (cfg_we) begin
        m_pos  = 0;
        m_mode = cfg_data[7];
        m_imm  = cfg_data[7];
`ifdef APU_FRAME_IRQ_EN
        m_inh = cfg_data[6];
        if (m_inh || irq_ack) m_irq = 0;
`endif
      end else begin
        m_pos++;
        m_imm = 0;
`ifdef APU_FRAME_IRQ_EN
        if (!m_mode && !m_inh && (m_pos % DIV == 0) && ((m_pos / DIV - 1) % 4 == 3))
          m_irq = 1;
        else if (irq_ack)
          m_irq = 0;
`endif
      end
      exp_q.push_back(model_out());
    end
  end

  // ---------------- scoreboard compare ----------------
  bit started = 0;
  bit collect = 0;
  int q_seen[$];
  int h_seen[$];
  int first_irq = -1;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (started) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("quarter_tick", int'(quarter_tick), int'(e[3]));
        check("half_tick",    int'(half_tick),    int'(e[4]));
        check("irq",          int'(irq),          int'(e[5]));
        check("step",         int'(step),         int'(e[2:0]));
      end
      if (collect) begin
        if (quarter_tick) q_seen.push_back(cyc);
        if (half_tick)    h_seen.push_back(cyc);
        if (irq && first_irq < 0) first_irq = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle_io(input logic we, input logic [7:0] d, input logic ack);
    cfg_we   = we;
    cfg_data = d;
    irq_ack  = ack;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_io(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    started = 1;
    collect = 1;
    rst_n   = 1'b1;
    check("reset_quarter", int'(quarter_tick), 0);
    check("reset_step",    int'(step),         0);

    // Idle from reset: hand-computed tick positions.
    idle(45);
    collect = 0;
    check("idle_q_count", q_seen.size(), 4);
    check("idle_h_count", h_seen.size(), 2);
    for (int i = 0; i < q_seen.size() && i < 4; i++) check("idle_q_cycle", q_seen[i], 10 * (i + 1));
    for (int i = 0; i < h_seen.size() && i < 2; i++) check("idle_h_cycle", h_seen[i], 20 * (i + 1));
`ifdef APU_FRAME_IRQ_EN
    check("idle_first_irq", first_irq, 40);
`else
    check("idle_first_irq", first_irq, -1);
`endif

    // irq_ack at cycle 45, frame end at 80 sets it again.
    cycle_io(1'b0, 8'h00, 1'b1);
    check("ack_irq_clear", int'(irq), 0);
    idle(39);
`ifdef APU_FRAME_IRQ_EN
    check("irq_reset_80", int'(irq), 1);
`else
    check("irq_reset_80", int'(irq), 0);
`endif

    // 5-step write: immediate double tick.
    cycle_io(1'b1, 8'h80, 1'b0);
    check("w5_quarter", int'(quarter_tick), 1);
    check("w5_half",    int'(half_tick),    1);
    check("w5_step",    int'(step),         0);
    idle(60);

    // Back to 4-step, then an inhibit write clears the flag.
    cycle_io(1'b1, 8'h00, 1'b0);
    idle(45);
    cycle_io(1'b1, 8'h40, 1'b0);
    check("inhibit_irq", int'(irq), 0);
    check("inhibit_quarter", int'(quarter_tick), 0);
    idle(130);

    // Write landing on the step-3 boundary of a 4-step frame.
    cycle_io(1'b1, 8'h00, 1'b0);
    idle(39);
    cycle_io(1'b1, 8'h00, 1'b0);
    check("bnd_step",    int'(step),         0);
    check("bnd_half",    int'(half_tick),    0);
    check("bnd_quarter", int'(quarter_tick), 0);
    check("bnd_irq",     int'(irq),          0);
    idle(10);
    check("bnd_next_quarter", int'(quarter_tick), 1);
    idle(45);

    // Asynchronous reset pulse mid-step.
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_quarter", int'(quarter_tick), 0);
    check("areset_half",    int'(half_tick),    0);
    check("areset_irq",     int'(irq),          0);
    check("areset_step",    int'(step),         0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(25);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle_io(($urandom_range(0, 59) == 0), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 9) == 0));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
